// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter (open-drain via output enables)
// Optional watchdog on device clock falls enabled by PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PS2_TX_TIMEOUT_EN
   localparam bit WDOG_EN = 1'b1;
`else
   localparam bit WDOG_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE, INHIBIT, RTS, SEND, STOP, ACK_SAMPLE, WAIT_IDLE
   } state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] clk_sync, data_sync;
   logic clk_s, data_s, clk_prev, fall;

   logic [8:0]    frame_q, frame_d;
   logic [3:0]    idx_q, idx_d;
   logic          bit_q, bit_d;
   logic [IW-1:0] inh_q, inh_d;
   logic [TW-1:0] to_q, to_d;
   logic          done_d, err_d;
   logic          watched, timeout;

   // Idle bus level is high, so synchronisers reset to 1 to avoid a false fall.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
         data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_in};
         clk_prev  <= clk_s;
      end
   end

   assign clk_s  = clk_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];
   assign fall   = clk_prev & ~clk_s;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         frame_q <= '0;
         idx_q   <= '0;
         bit_q   <= 1'b0;
         inh_q   <= '0;
         to_q    <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         idx_q   <= idx_d;
         bit_q   <= bit_d;
         inh_q   <= inh_d;
         to_q    <= to_d;
         done    <= done_d;
         err     <= err_d;
      end
   end

   assign watched = (state_q == SEND) || (state_q == STOP) ||
                    (state_q == ACK_SAMPLE) || (state_q == WAIT_IDLE);
   assign timeout = WDOG_EN && watched && (to_q == TW'(TIMEOUT_CYCLES));
   assign busy    = (state_q != IDLE);

   always_comb begin
      state_d     = state_q;
      frame_d     = frame_q;
      idx_d       = idx_q;
      bit_d       = bit_q;
      inh_d       = inh_q;
      to_d        = to_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;

      if (WDOG_EN && watched) begin
         if (fall)
            to_d = '0;
         else if (to_q != TW'(TIMEOUT_CYCLES))
            to_d = to_q + TW'(1);
      end

      case (state_q)
         IDLE: begin
            if (tx_start) begin
               frame_d = {~^tx_data, tx_data};
               inh_d   = '0;
               state_d = INHIBIT;
            end
         end
         INHIBIT: begin
            ps2_clk_oe = 1'b1;
            if (inh_q >= IW'(INHIBIT_CYCLES - 1))
               state_d = RTS;
            else
               inh_d = inh_q + IW'(1);
         end
         RTS: begin
            ps2_clk_oe  = 1'b1;
            ps2_data_oe = 1'b1;
            bit_d       = 1'b0;
            idx_d       = '0;
            to_d        = '0;
            state_d     = SEND;
         end
         SEND: begin
            // bit_q holds the level on the wire; it starts as the start bit.
            ps2_data_oe = ~bit_q;
            if (fall) begin
               if (idx_q == 4'd9) begin
                  state_d = STOP;
               end else begin
                  bit_d = frame_q[idx_q];
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         STOP: begin
            if (fall)
               state_d = ACK_SAMPLE;
         end
         ACK_SAMPLE: begin
            if (data_s) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (clk_s && data_s) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (timeout) begin
         done_d  = 1'b0;
         err_d   = 1'b1;
         state_d = IDLE;
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - randomized bench for ps2_host_tx with a behavioural PS/2 device model
module tb_ps2_host_tx;

   localparam int INH  = 40;
   localparam int TOUT = 300;
   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_start = 1'b0;
   logic       ps2_clk_oe, ps2_data_oe, busy, done, err;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       clk_line, data_line;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int err_cyc = 0;
   int fall_cyc = 0;

   assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
   assign data_line = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TOUT),
      .SYNC_STAGES(SYNC)
   ) dut (
      .clk(clk),
      .reset(reset),
      .tx_data(tx_data),
      .tx_start(tx_start),
      .ps2_clk_in(clk_line),
      .ps2_data_in(data_line),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe),
      .busy(busy),
      .done(done),
      .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done) begin
         done_cnt++;
         chk("busy_at_done", busy, 0);
      end
      if (err) begin
         err_cnt++;
         err_cyc = cyc;
         chk("busy_at_err", busy, 0);
      end
      if (done || err) chk("done_err_excl", done & err, 0);
   end

   // Expected wire frame: start, LSB-first data, odd parity, stop.
   function automatic logic [10:0] model_frame(input logic [7:0] d);
      logic [10:0] f;
      int ones;
      ones = 0;
      f = '0;
      for (int i = 0; i < 8; i++) begin
         f[i + 1] = d[i];
         ones += int'(d[i]);
      end
      f[9]  = (ones % 2 == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   task automatic device_frame(input int h, input bit ack, input int nfalls, output logic [10:0] bits);
      int guard;
      bits  = '0;
      guard = 0;
      while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      chk("rts_seen", guard < 1000, 1);
      repeat (h) @(negedge clk);
      bits[0] = data_line;
      for (int k = 1; k <= nfalls; k++) begin
         if (k == 11 && ack) dev_data_low = 1'b1;
         repeat (h) @(negedge clk);
         dev_clk_low = 1'b1;
         fall_cyc = cyc;
         repeat (h / 2) @(negedge clk);
         if (k <= 10) bits[k] = data_line;
         repeat (h - h / 2) @(negedge clk);
         dev_clk_low = 1'b0;
      end
      repeat (h) @(negedge clk);
      dev_data_low = 1'b0;
   endtask

   task automatic start_and_inhibit(input logic [7:0] d);
      int n;
      @(negedge clk);
      tx_data  = d;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      tx_data  = 8'($urandom);
      chk("busy_after_start", busy, 1);
      n = 0;
      while (ps2_clk_oe && !ps2_data_oe && n < INH + 100) begin
         n++;
         @(negedge clk);
      end
      chk("inhibit_len", n, INH);
      chk("rts_lines", {ps2_clk_oe, ps2_data_oe}, 2'b11);
      @(negedge clk);
      chk("send_lines", {ps2_clk_oe, ps2_data_oe}, 2'b01);
   endtask

   task automatic run_frame(input logic [7:0] d, input int h, input bit ack, input bit inject);
      logic [10:0] bits;
      int d0, e0, n;
      d0 = done_cnt;
      e0 = err_cnt;
      start_and_inhibit(d);
      fork
         device_frame(h, ack, 11, bits);
         begin
            if (inject) begin
               repeat (3 * h) @(negedge clk);
               tx_data  = 8'h00;
               tx_start = 1'b1;
               @(negedge clk);
               tx_start = 1'b0;
            end
         end
      join
      n = 0;
      while (done_cnt == d0 && err_cnt == e0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
      chk("frame_bits", bits, model_frame(d));
      chk("done_count", done_cnt - d0, ack ? 1 : 0);
      chk("err_count", err_cnt - e0, ack ? 0 : 1);
      chk("idle_after", {busy, ps2_clk_oe, ps2_data_oe}, 3'b000);
   endtask

   initial begin
      logic [10:0] tbits;
      int d0, e0, n;

      repeat (3) @(negedge clk);
      chk("reset_outs", {ps2_clk_oe, ps2_data_oe, busy, done, err}, 5'b00000);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_outs", {ps2_clk_oe, ps2_data_oe, busy, done, err}, 5'b00000);

      run_frame(8'hED, 20, 1'b1, 1'b1);
      run_frame(8'hF4, 16, 1'b1, 1'b0);
      run_frame(8'hED, 18, 1'b0, 1'b0);
      run_frame(8'h00, 14, 1'b1, 1'b0);
      run_frame(8'hFF, 14, 1'b1, 1'b0);

      for (int i = 0; i < 10; i++)
         run_frame(8'($urandom), int'($urandom_range(30, 14)), 1'($urandom_range(3, 0) != 0), 1'($urandom));

      // Reset asserted in the middle of the inhibit phase.
      d0 = done_cnt;
      e0 = err_cnt;
      @(negedge clk);
      tx_data  = 8'hA5;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      repeat (INH / 2) @(negedge clk);
      chk("mid_inhibit_clk_oe", ps2_clk_oe, 1);
      #2 reset = 1'b0;
      #1 chk("reset_abort_lines", {ps2_clk_oe, ps2_data_oe, busy}, 3'b000);
      @(negedge clk);
      reset = 1'b1;
      repeat (INH + 20) @(negedge clk);
      chk("reset_abort_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
      chk("reset_abort_idle", {busy, ps2_clk_oe}, 2'b00);

      // Device falls silent after four clock falls.
      d0 = done_cnt;
      e0 = err_cnt;
      start_and_inhibit(8'h5A);
      device_frame(16, 1'b0, 4, tbits);
`ifdef PS2_TX_TIMEOUT_EN
      n = 0;
      while (err_cnt == e0 && n < TOUT + 200) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_err", err_cnt - e0, 1);
      chk("timeout_delay_ok", (err_cyc - fall_cyc >= TOUT) && (err_cyc - fall_cyc <= TOUT + 12), 1);
      repeat (5) @(negedge clk);
      chk("timeout_idle", {busy, ps2_clk_oe, ps2_data_oe}, 3'b000);
      chk("timeout_no_done", done_cnt - d0, 0);
`else
      repeat (2 * TOUT) @(negedge clk);
      chk("silent_busy", busy, 1);
      chk("silent_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
      #2 reset = 1'b0;
      #1 chk("silent_reset_lines", {ps2_clk_oe, ps2_data_oe, busy}, 3'b000);
      @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
`endif

      run_frame(8'hF4, 20, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
